execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameter WIDTH, default 32, data/address word width in bits (power of two, >=8).
REQ-002 Parameter REG_BITS, default 5, destination register index width.
REQ-003 Port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port flush  in  1  synchronous pipeline flush from branch resolution.
REQ-006 Port in_valid  in  1  upstream (read stage) presents a valid instruction.
REQ-007 Port in_hold  out  1  stall request to upstream; upstream holds its outputs while high.
REQ-008 Port in_pc  in  WIDTH  instruction address.
REQ-009 Port in_operation  in  4  opcode (encoding per REQ-020).
REQ-010 Port in_destination  in  REG_BITS  destination register index.
REQ-011 Port in_left, in_right  in  WIDTH each  operand values (in_right already holds load data for loads).
REQ-012 Port in_adjustment  in  WIDTH  address offset for stores.
REQ-013 Port in_is_writing_memory  in  1  instruction is a store.
REQ-014 Port out_valid  out  1  downstream (write stage) output bundle valid.
REQ-015 Port out_hold  in  1  downstream stall; all out_* registers freeze while high.
REQ-016 Port out_pc / out_destination / out_result  out  WIDTH / REG_BITS / WIDTH  registered pc, destination, ALU result.
REQ-017 Port out_is_writing_memory / out_address / out_data  out  1 / WIDTH / WIDTH  registered store request, address, data.

Function
REQ-018 All out_* ports SHALL be registers; the block has no combinational path from in_* data to out_*.
REQ-019 When out_hold=1 and flush=0, every out_* register and the FSM SHALL hold their values.
REQ-020 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 SRA, 8 SLT signed, 9 SLTU, 10 MUL, 11 PASS (result=in_right); 12-15 result 0.
REQ-021 Arithmetic SHALL wrap modulo 2^WIDTH; shift amount SHALL be in_right[log2(WIDTH)-1:0]; SLT/SLTU SHALL yield 1 or 0, zero-extended.
REQ-022 Non-MUL ops, in_valid=1, out_hold=0, flush=0: outputs SHALL load at the next edge with out_valid=1 (latency 1 cycle) and in_hold=0.
REQ-023 Stores: out_address SHALL be in_left+in_adjustment (mod 2^WIDTH), out_data SHALL be in_right, out_result SHALL be 0.
REQ-024 FSM states IDLE, MULTIPLY, DONE; reset state IDLE.
REQ-025 IDLE and in_valid=1 with opcode MUL and flush=0: load multiplicand=in_left, multiplier=in_right, accumulator=0, count=0, go to MULTIPLY (regardless of out_hold).
REQ-026 MULTIPLY: each cycle add multiplicand to accumulator if multiplier[0]=1, shift multiplicand left 1, multiplier right 1, count+1; after the iteration with count=WIDTH-1 go to DONE.
REQ-027 DONE with out_hold=0: load outputs with out_result=accumulator (low WIDTH bits of product), out_valid=1, return to IDLE; with out_hold=1 remain in DONE.
REQ-028 in_hold SHALL equal in_valid AND NOT flush AND (out_hold OR state=MULTIPLY OR (state=IDLE AND opcode=MUL)); a MUL therefore takes WIDTH+2 edges from acceptance to out_valid.
REQ-029 When out_hold=0 and no instruction completes this cycle (in_valid=0, or MUL in progress), out_valid SHALL be 0 at the next edge.
REQ-030 flush=1 SHALL take priority over out_hold: at the next edge out_valid=0, FSM=IDLE, count=0; the in-flight instruction is discarded.

Reset
REQ-031 While reset=1: out_valid=0, out_is_writing_memory=0, out_pc/out_destination/out_result/out_address/out_data=0, FSM=IDLE, count=0, independent of clock.
REQ-032 Reset asserted mid-MULTIPLY SHALL abandon the multiply; after release the block SHALL accept a new instruction on the first edge.

Verification
REQ-033 ADD left=0xFFFFFFFF right=2, out_hold=0 -> next cycle out_valid=1, out_result=0x00000001.
REQ-034 SRA left=0x80000000 right=0x24 -> out_result=0xF8000000 (shift 4); SLT left=-1 right=1 -> 1; SLTU same operands -> 0.
REQ-035 MUL left=7 right=6 -> in_hold high for 33 cycles, out_valid=1 with out_result=42 on edge 34 after acceptance; MUL 0x10000 x 0x10000 -> 0.
REQ-036 Store left=0x1000 adj=0xFFFFFFFC right=0xAB -> out_address=0x0FFC, out_data=0xAB, out_is_writing_memory=1; hold out_hold=1 for 3 cycles -> outputs unchanged.
REQ-037 Flush at MULTIPLY cycle 10 with out_hold=1 -> next edge out_valid=0, FSM=IDLE, in_hold=0; following ADD 3+4 -> out_result=7.
REQ-038 Assert reset asynchronously mid-MUL -> all outputs 0 immediately; release, SUB 5-7 -> out_result=0xFFFFFFFE.

Source files
------------

// File: rtl/execute.sv
// execute: single-issue ALU stage with a sequential shift-add multiplier.
// Results and store requests are registered toward the write stage.
`default_nettype none

module execute #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_hold,
  input  logic [WIDTH-1:0]    in_pc,
  input  logic [3:0]          in_operation,
  input  logic [REG_BITS-1:0] in_destination,
  input  logic [WIDTH-1:0]    in_left,
  input  logic [WIDTH-1:0]    in_right,
  input  logic [WIDTH-1:0]    in_adjustment,
  input  logic                in_is_writing_memory,
  output logic                out_valid,
  input  logic                out_hold,
  output logic [WIDTH-1:0]    out_pc,
  output logic [REG_BITS-1:0] out_destination,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_is_writing_memory,
  output logic [WIDTH-1:0]    out_address,
  output logic [WIDTH-1:0]    out_data
);

  localparam int SHAMT_BITS = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]      multiplicand;
  logic [WIDTH-1:0]      multiplier;
  logic [WIDTH-1:0]      accumulator;
  logic [SHAMT_BITS-1:0] count;
  logic [WIDTH-1:0]      mul_pc;
  logic [REG_BITS-1:0]   mul_destination;

  logic                  is_mul_request;
  logic                  last_iteration;
  logic [SHAMT_BITS-1:0] shamt;
  logic [WIDTH-1:0]      alu_result;

  assign is_mul_request = in_valid && !flush && (in_operation == OP_MUL);
  assign last_iteration = (count == SHAMT_BITS'(WIDTH - 1));
  assign shamt          = in_right[SHAMT_BITS-1:0];

  assign in_hold = in_valid && !flush &&
                   (out_hold || (state == MULTIPLY) ||
                    ((state == IDLE) && (in_operation == OP_MUL)));

  always_comb begin
    alu_result = '0;
    case (in_operation)
      OP_ADD:  alu_result = in_left + in_right;
      OP_SUB:  alu_result = in_left - in_right;
      OP_AND:  alu_result = in_left & in_right;
      OP_OR:   alu_result = in_left | in_right;
      OP_XOR:  alu_result = in_left ^ in_right;
      OP_SHL:  alu_result = in_left << shamt;
      OP_SHR:  alu_result = in_left >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(in_left) >>> shamt);
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(in_left) < $signed(in_right)};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, in_left < in_right};
      OP_PASS: alu_result = in_right;
      default: alu_result = '0;
    endcase
  end

  // Leaving IDLE for a multiply ignores out_hold; every other move waits for it.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (is_mul_request) state_next = MULTIPLY;
        MULTIPLY: if (!out_hold && last_iteration) state_next = DONE;
        DONE:     if (!out_hold) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      multiplicand    <= '0;
      multiplier      <= '0;
      accumulator     <= '0;
      count           <= '0;
      mul_pc          <= '0;
      mul_destination <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (state == IDLE) begin
      if (is_mul_request) begin
        multiplicand    <= in_left;
        multiplier      <= in_right;
        accumulator     <= '0;
        count           <= '0;
        mul_pc          <= in_pc;
        mul_destination <= in_destination;
      end
    end else if (state == MULTIPLY && !out_hold) begin
      if (multiplier[0]) accumulator <= accumulator + multiplicand;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      count        <= count + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid             <= 1'b0;
      out_pc                <= '0;
      out_destination       <= '0;
      out_result            <= '0;
      out_is_writing_memory <= 1'b0;
      out_address           <= '0;
      out_data              <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_hold) begin
      if (state == IDLE && in_valid && in_operation != OP_MUL) begin
        out_valid             <= 1'b1;
        out_pc                <= in_pc;
        out_destination       <= in_destination;
        out_is_writing_memory <= in_is_writing_memory;
        out_result            <= in_is_writing_memory ? '0 : alu_result;
        out_address           <= in_is_writing_memory ? in_left + in_adjustment : '0;
        out_data              <= in_is_writing_memory ? in_right : '0;
      end else if (state == DONE) begin
        out_valid             <= 1'b1;
        out_pc                <= mul_pc;
        out_destination       <= mul_destination;
        out_is_writing_memory <= 1'b0;
        out_result            <= accumulator;
        out_address           <= '0;
        out_data              <= '0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute.sv
// Scoreboard bench for execute: directed corner cases plus randomized traffic.
`default_nettype none

module tb_execute;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_hold;
  logic [31:0] in_pc = '0;
  logic [3:0]  in_operation = '0;
  logic [4:0]  in_destination = '0;
  logic [31:0] in_left = '0;
  logic [31:0] in_right = '0;
  logic [31:0] in_adjustment = '0;
  logic        in_is_writing_memory = 1'b0;
  logic        out_valid;
  logic        out_hold = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_destination;
  logic [31:0] out_result;
  logic        out_is_writing_memory;
  logic [31:0] out_address;
  logic [31:0] out_data;

  execute #(.WIDTH(32), .REG_BITS(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_hold(in_hold), .in_pc(in_pc),
    .in_operation(in_operation), .in_destination(in_destination),
    .in_left(in_left), .in_right(in_right), .in_adjustment(in_adjustment),
    .in_is_writing_memory(in_is_writing_memory),
    .out_valid(out_valid), .out_hold(out_hold), .out_pc(out_pc),
    .out_destination(out_destination), .out_result(out_result),
    .out_is_writing_memory(out_is_writing_memory),
    .out_address(out_address), .out_data(out_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        wm;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  logic rand_hold = 1'b0;
  logic [31:0] pc_ctr = 32'h100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r);
    int s;
    s = int'(r % 32);
    case (op)
      4'd0:  return l + r;
      4'd1:  return l - r;
      4'd2:  return l & r;
      4'd3:  return l | r;
      4'd4:  return l ^ r;
      4'd5:  return l << s;
      4'd6:  return l >> s;
      4'd7:  return l[31] ? ~((~l) >> s) : (l >> s);
      4'd8:  return (int'(l) < int'(r)) ? 32'd1 : 32'd0;
      4'd9:  return (l < r) ? 32'd1 : 32'd0;
      4'd10: return 32'((64'(l) * 64'(r)) % 64'h1_0000_0000);
      4'd11: return r;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom % 4)
      0:       return 32'($urandom % 16);
      1:       return 32'hFFFF_FFFF - 32'($urandom % 16);
      2:       return 32'($urandom);
      default: return 32'd1 << ($urandom % 32);
    endcase
  endfunction

  // An output is handed downstream whenever it is valid and not held, or flushed away.
  always @(negedge clock) begin
    if (!reset && out_valid && (!out_hold || flush)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual_pc=%h required=none", out_pc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_destination", 32'(out_destination), 32'(e.dest));
        check("out_result", out_result, e.result);
        check("out_is_writing_memory", 32'(out_is_writing_memory), 32'(e.wm));
        check("out_address", out_address, e.addr);
        check("out_data", out_data, e.data);
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_hold) out_hold = (($urandom % 4) == 0);
  end

  task automatic present(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] adj, input logic wm);
    pc_ctr               = pc_ctr + 4;
    in_pc                = pc_ctr;
    in_operation         = op;
    in_destination       = 5'($urandom % 32);
    in_left              = l;
    in_right             = r;
    in_adjustment        = adj;
    in_is_writing_memory = wm;
    in_valid             = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] adj, input logic wm, output int hold_cycles);
    exp_t e;
    hold_cycles = 0;
    present(op, l, r, adj, wm);
    forever begin
      @(negedge clock);
      if (!in_hold) break;
      hold_cycles++;
      if (hold_cycles > 300) begin
        checks++;
        failures++;
        $display("FAIL handshake_timeout actual=in_hold_stuck required=release");
        break;
      end
    end
    e.pc     = in_pc;
    e.dest   = in_destination;
    e.wm     = wm;
    e.result = wm ? 32'd0 : model(op, l, r);
    e.addr   = wm ? l + adj : 32'd0;
    e.data   = wm ? r : 32'd0;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_pc"}, out_pc, 32'd0);
    check({tag, "_out_destination"}, 32'(out_destination), 32'd0);
    check({tag, "_out_result"}, out_result, 32'd0);
    check({tag, "_out_is_writing_memory"}, 32'(out_is_writing_memory), 32'd0);
    check({tag, "_out_address"}, out_address, 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hc;
    #12;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    issue(4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, hc);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", out_result, 32'h0000_0001);
    check("add_hold_cycles", 32'(hc), 32'd0);
    issue(4'd7, 32'h8000_0000, 32'h24, 32'd0, 1'b0, hc);
    check("sra_result", out_result, 32'hF800_0000);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, hc);
    check("slt_result", out_result, 32'd1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, hc);
    check("sltu_result", out_result, 32'd0);

    issue(4'd10, 32'd7, 32'd6, 32'd0, 1'b0, hc);
    check("mul_hold_cycles", 32'(hc), 32'd33);
    check("mul_valid", 32'(out_valid), 32'd1);
    check("mul_result", out_result, 32'd42);
    issue(4'd10, 32'h1_0000, 32'h1_0000, 32'd0, 1'b0, hc);
    check("mul_wrap_result", out_result, 32'd0);

    issue(4'd0, 32'h1000, 32'hAB, 32'hFFFF_FFFC, 1'b1, hc);
    out_hold = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("store_held_valid", 32'(out_valid), 32'd1);
      check("store_held_address", out_address, 32'h0000_0FFC);
      check("store_held_data", out_data, 32'h0000_00AB);
      check("store_held_wm", 32'(out_is_writing_memory), 32'd1);
      check("store_held_result", out_result, 32'd0);
    end
    @(posedge clock);
    #1;
    out_hold = 1'b0;
    idle(3);

    out_hold = 1'b1;
    present(4'd10, 32'd9, 32'd9, 32'd0, 1'b0);
    idle(11);
    flush = 1'b1;
    @(negedge clock);
    check("flush_in_hold", 32'(in_hold), 32'd0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_hold = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    issue(4'd0, 32'd3, 32'd4, 32'd0, 1'b0, hc);
    check("post_flush_hold_cycles", 32'(hc), 32'd0);
    check("post_flush_result", out_result, 32'd7);
    idle(3);

    present(4'd10, 32'd123, 32'd456, 32'd0, 1'b0);
    idle(6);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    issue(4'd1, 32'd5, 32'd7, 32'd0, 1'b0, hc);
    check("post_reset_hold_cycles", 32'(hc), 32'd0);
    check("post_reset_result", out_result, 32'hFFFF_FFFE);

    rand_hold = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [3:0] op;
      logic       wm;
      op = 4'($urandom % 16);
      wm = (($urandom % 4) == 0) && (op != 4'd10);
      issue(op, rnd_operand(), rnd_operand(), rnd_operand(), wm, hc);
      if (($urandom % 5) == 0) idle(1);
    end
    rand_hold = 1'b0;
    @(posedge clock);
    #1;
    out_hold = 1'b0;
    idle(5);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
